// File: rtl/game_pkg.sv
// Shared direction types, scheduler FSM states and the round-robin pick helper
// used by the move scheduler slice.
package game_pkg;

    typedef logic [1:0] dir_t;

    localparam dir_t DIR_UP    = 2'd0;
    localparam dir_t DIR_DOWN  = 2'd1;
    localparam dir_t DIR_LEFT  = 2'd2;
    localparam dir_t DIR_RIGHT = 2'd3;

    localparam int unsigned NUM_DIRS = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_SETTLE
    } sched_state_t;

    // Returns {found, dir}: first set bit of req scanning upward from ptr, wrapping.
    function automatic logic [2:0] rr_pick(input logic [NUM_DIRS-1:0] req, input dir_t ptr);
        logic [2:0] r;
        dir_t       d;
        r = '0;
        for (int unsigned i = 0; i < NUM_DIRS; i++) begin
            d = dir_t'(ptr + 2'(i));
            if (!r[2] && req[d]) begin
                r = {1'b1, d};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/move_scheduler_if.sv
// Move command handshake between the scheduler (master) and the position updater (slave).
interface move_scheduler_if;
    import game_pkg::*;

    logic move_valid;
    dir_t move_dir;
    logic move_ready;

    modport master (output move_valid, output move_dir, input move_ready);
    modport slave  (input move_valid, input move_dir, output move_ready);

endinterface

// File: rtl/btn_autorepeat.sv
// Per-direction press edge detector with hold-to-repeat timing and a sticky request
// flag that stays pending until the scheduler clears it.
module btn_autorepeat #(
    parameter int unsigned REPEAT_DELAY = 12,
    parameter int unsigned REPEAT_RATE  = 4,
    parameter int unsigned CNT_W        = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic btn,
    input  logic clr,
    output logic req
);

    logic             r_btn_q;
    logic [CNT_W-1:0] r_rpt_cnt;
    logic             r_req;
    logic             w_edge;
    logic             w_fire;

    assign w_edge = btn & ~r_btn_q;
    // Fire on the tick that would bring the count up to REPEAT_DELAY.
    assign w_fire = !w_edge && btn && tick && (r_rpt_cnt == CNT_W'(REPEAT_DELAY - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_btn_q   <= 1'b0;
            r_rpt_cnt <= '0;
            r_req     <= 1'b0;
        end else begin
            r_btn_q <= btn;
            if (w_edge || !btn) begin
                r_rpt_cnt <= '0;
            end else if (tick) begin
                r_rpt_cnt <= w_fire ? CNT_W'(REPEAT_DELAY - REPEAT_RATE) : r_rpt_cnt + CNT_W'(1);
            end
            r_req <= (r_req & ~clr) | w_edge | w_fire;
        end
    end

    assign req = r_req;

endmodule

// File: rtl/move_scheduler.sv
// Arbitrates gravity and button requests into one gated move command per
// handshake, followed by a settle window for the enables to re-evaluate.
module move_scheduler
    import game_pkg::*;
#(
    parameter int unsigned REPEAT_DELAY   = 12,
    parameter int unsigned REPEAT_RATE    = 4,
    parameter int unsigned GRAVITY_PERIOD = 30,
    parameter int unsigned SETTLE_CYCLES  = 2,
    parameter int unsigned CNT_W          = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tick,
    input  logic [NUM_DIRS-1:0] btn,
    input  logic [NUM_DIRS-1:0] en,
    move_scheduler_if.master    mv,
    output logic                landed,
    output logic                busy
);

    logic [NUM_DIRS-1:0] w_req;
    logic [NUM_DIRS-1:0] w_clr;

    for (genvar g = 0; g < NUM_DIRS; g++) begin : g_rpt
        btn_autorepeat #(
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE),
            .CNT_W        (CNT_W)
        ) u_rpt (
            .clk   (clk),
            .rst_n (rst_n),
            .tick  (tick),
            .btn   (btn[g]),
            .clr   (w_clr[g]),
            .req   (w_req[g])
        );
    end

    logic [CNT_W-1:0] r_grav_cnt;
    logic             r_grav_pend;
    logic             w_grav_wrap;
    logic             w_grav_clr;

    assign w_grav_wrap = tick && (r_grav_cnt == CNT_W'(GRAVITY_PERIOD - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_grav_cnt  <= '0;
            r_grav_pend <= 1'b0;
        end else begin
            if (tick) begin
                r_grav_cnt <= w_grav_wrap ? '0 : r_grav_cnt + CNT_W'(1);
            end
            r_grav_pend <= (r_grav_pend & ~w_grav_clr) | w_grav_wrap;
        end
    end

    sched_state_t     r_state;
    sched_state_t     w_state_nxt;
    dir_t             r_dir;
    dir_t             w_dir_nxt;
    dir_t             r_rr_ptr;
    logic [CNT_W-1:0] r_settle;
    logic             r_landed;
    logic             w_landed_nxt;
    logic [2:0]       w_pick;
    logic             w_pick_vld;
    dir_t             w_pick_dir;

    assign w_pick     = rr_pick(w_req, r_rr_ptr);
    assign w_pick_vld = w_pick[2];
    assign w_pick_dir = w_pick[1:0];

    always_comb begin
        w_state_nxt  = r_state;
        w_dir_nxt    = r_dir;
        w_clr        = '0;
        w_grav_clr   = 1'b0;
        w_landed_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Gravity outranks buttons; a blocked down-step means landing.
                if (r_grav_pend) begin
                    w_grav_clr = 1'b1;
                    if (en[DIR_DOWN]) begin
                        w_clr[DIR_DOWN] = 1'b1;
                        w_dir_nxt       = DIR_DOWN;
                        w_state_nxt     = ST_ISSUE;
                    end else begin
                        w_landed_nxt = 1'b1;
                    end
                end else if (w_pick_vld) begin
                    w_clr[w_pick_dir] = 1'b1;
                    if (en[w_pick_dir]) begin
                        w_dir_nxt   = w_pick_dir;
                        w_state_nxt = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (mv.move_ready) begin
                    w_state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (r_settle == CNT_W'(1)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_dir    <= DIR_UP;
            r_rr_ptr <= DIR_UP;
            r_settle <= '0;
            r_landed <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_dir    <= w_dir_nxt;
            r_landed <= w_landed_nxt;
            if (r_state == ST_ISSUE && mv.move_ready) begin
                r_rr_ptr <= dir_t'(r_dir + 2'd1);
                r_settle <= CNT_W'(SETTLE_CYCLES);
            end else if (r_state == ST_SETTLE) begin
                r_settle <= r_settle - CNT_W'(1);
            end
        end
    end

    assign mv.move_valid = (r_state == ST_ISSUE);
    assign mv.move_dir   = r_dir;
    assign busy          = (r_state != ST_IDLE);
    assign landed        = r_landed;

endmodule

// File: tb/tb_move_scheduler.sv
// Directed scenarios plus a randomized run, every cycle compared against a
// behavioural model of the move scheduler rules.
module tb_move_scheduler;
    import game_pkg::*;

    localparam int RD = 12;
    localparam int RR = 4;
    localparam int GP = 30;
    localparam int SC = 2;
    localparam int CW = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick;
    logic [3:0] btn;
    logic [3:0] en;
    logic       ready;
    logic       landed;
    logic       busy;

    move_scheduler_if u_if ();
    assign u_if.move_ready = ready;

    move_scheduler #(
        .REPEAT_DELAY   (RD),
        .REPEAT_RATE    (RR),
        .GRAVITY_PERIOD (GP),
        .SETTLE_CYCLES  (SC),
        .CNT_W          (CW)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick   (tick),
        .btn    (btn),
        .en     (en),
        .mv     (u_if),
        .landed (landed),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Behavioural model: hold time measured in ticks, pending set per direction,
    // total tick count for gravity, and a remaining-settle counter.
    bit m_prev [4];
    int m_held [4];
    bit m_pend [4];
    int m_ticks;
    bit m_gpend;
    bit m_valid;
    int m_dir;
    int m_wait;
    bit m_landed;
    int m_ptr;

    int step_no, tick_div, tick_phase, ticks_seen;
    int moves, lands, busy_cnt, first_valid, acc_step;
    int dir_log [$];

    task automatic model_reset();
        for (int d = 0; d < 4; d++) begin
            m_prev[d] = 0; m_held[d] = 0; m_pend[d] = 0;
        end
        m_ticks = 0; m_gpend = 0; m_valid = 0; m_dir = 0;
        m_wait = 0; m_landed = 0; m_ptr = 0;
    endtask

    task automatic model_step();
        int grant;
        bit new_land;
        grant = -1;
        new_land = 0;
        if (!rst_n) begin
            model_reset();
        end else begin
            if (!m_valid && m_wait == 0) begin
                if (m_gpend) begin
                    m_gpend = 0;
                    if (en[1]) begin
                        grant = 1; m_pend[1] = 0;
                    end else begin
                        new_land = 1;
                    end
                end else begin
                    for (int k = 0; k < 4; k++) begin
                        int d;
                        d = (m_ptr + k) % 4;
                        if (m_pend[d]) begin
                            m_pend[d] = 0;
                            if (en[d]) grant = d;
                            break;
                        end
                    end
                end
            end
            if (m_valid && ready) begin
                m_ptr = (m_dir + 1) % 4; m_valid = 0; m_wait = SC;
            end else if (m_wait > 0) begin
                m_wait--;
            end
            if (grant >= 0) begin
                m_valid = 1; m_dir = grant;
            end
            for (int d = 0; d < 4; d++) begin
                if (btn[d] && !m_prev[d]) begin
                    m_pend[d] = 1; m_held[d] = 0;
                end else if (btn[d]) begin
                    if (tick) begin
                        m_held[d]++;
                        if (m_held[d] == RD || (m_held[d] > RD && (m_held[d] - RD) % RR == 0))
                            m_pend[d] = 1;
                    end
                end else begin
                    m_held[d] = 0;
                end
                m_prev[d] = btn[d];
            end
            if (tick) begin
                m_ticks++;
                if (m_ticks % GP == 0) m_gpend = 1;
            end
            m_landed = new_land;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d (step %0d)", tag, obs, exp, step_no);
        end
    endtask

    task automatic compare_outputs();
        chk("move_valid", 32'(u_if.move_valid), 32'(m_valid));
        chk("busy", 32'(busy), 32'(m_valid || m_wait > 0));
        chk("landed", 32'(landed), 32'(m_landed));
        if (m_valid) chk("move_dir", 32'(u_if.move_dir), 32'(m_dir));
    endtask

    task automatic step();
        if (tick_div > 0) tick = (tick_phase == 0);
        else if (tick_div == 0) tick = 1'b0;
        if (tick && rst_n) ticks_seen++;
        if (rst_n && u_if.move_valid && ready) begin
            moves++;
            dir_log.push_back(int'(u_if.move_dir));
            acc_step = step_no;
        end
        @(posedge clk);
        model_step();
        @(negedge clk);
        step_no++;
        compare_outputs();
        if (u_if.move_valid && first_valid < 0) first_valid = step_no;
        if (landed) lands++;
        if (busy) busy_cnt++;
        if (tick_div > 0) tick_phase = (tick_phase + 1) % tick_div;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_stats();
        moves = 0; lands = 0; busy_cnt = 0; first_valid = -1;
        acc_step = -1; ticks_seen = 0; tick_phase = 0;
        dir_log.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; btn = '0; tick_div = 0;
        run(3);
        rst_n = 1'b1;
        clear_stats();
    endtask

    task automatic wait_cond_valid_dir(input int dir, input int maxc);
        int n;
        n = 0;
        while (!(u_if.move_valid && int'(u_if.move_dir) == dir) && n < maxc) begin
            step(); n++;
        end
        chk("wait_bound", 32'(n < maxc), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p, n, a_left, up_step;
        rst_n = 1'b0; tick = 1'b0; btn = '0; en = 4'hF; ready = 1'b1;
        step_no = 0; tick_div = 0;
        model_reset();
        clear_stats();

        do_reset();
        chk("rst_valid", 32'(u_if.move_valid), 32'd0);
        chk("rst_dir", 32'(u_if.move_dir), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_landed", 32'(landed), 32'd0);

        // 1: single tap, latency and busy window
        en = 4'hF; ready = 1'b1;
        btn = 4'b0100; step(); p = step_no; btn = '0;
        run(15);
        chk("t1_moves", 32'(moves), 32'd1);
        chk("t1_dir", 32'(dir_log[0]), 32'd2);
        chk("t1_latency", 32'(first_valid - p), 32'd1);
        chk("t1_busy", 32'(busy_cnt), 32'(1 + SC));

        // 2: hold right for 24 ticks
        do_reset();
        tick_div = 10; tick_phase = 1;
        btn = 4'b1000; step();
        n = 0;
        while (ticks_seen < 24 && n < 400) begin step(); n++; end
        btn = '0;
        run(20);
        chk("t2_moves", 32'(moves), 32'd5);
        for (int i = 0; i < 5 && i < dir_log.size(); i++) chk("t2_dir", 32'(dir_log[i]), 32'd3);

        // 3: gravity blocked then free
        do_reset();
        en = 4'b1101; tick_div = 2;
        run(64);
        chk("t3_landed", 32'(lands), 32'd1);
        chk("t3_nomove", 32'(moves), 32'd0);
        en = 4'hF;
        run(66);
        chk("t3_lands2", 32'(lands), 32'd1);
        chk("t3_moves", 32'(moves), 32'd1);
        if (dir_log.size() > 0) chk("t3_dir", 32'(dir_log[0]), 32'd1);

        // 4: stall with tap during stall
        do_reset();
        en = 4'hF; ready = 1'b0;
        btn = 4'b0100; step(); btn = '0;
        wait_cond_valid_dir(2, 20);
        for (int i = 0; i < 5; i++) begin
            btn = (i == 1) ? 4'b0001 : 4'b0000;
            step();
            chk("t4_stall_valid", 32'(u_if.move_valid), 32'd1);
            chk("t4_stall_dir", 32'(u_if.move_dir), 32'd2);
        end
        btn = '0; ready = 1'b1;
        wait_cond_valid_dir(0, 30);
        a_left = acc_step; up_step = step_no;
        chk("t4_up_delay", 32'(up_step - (a_left + 1)), 32'(SC + 1));
        run(10);
        chk("t4_moves", 32'(moves), 32'd2);

        // 5: disabled direction drops request
        do_reset();
        en = 4'b1011;
        btn = 4'b0100; step(); btn = '0;
        run(10);
        en = 4'hF;
        run(10);
        chk("t5_moves", 32'(moves), 32'd0);
        chk("t5_first", 32'(first_valid), 32'hFFFF_FFFF);

        // 6: four taps, round-robin order; then reset mid second issue
        do_reset();
        btn = 4'hF; step(); btn = '0;
        run(30);
        chk("t6_moves", 32'(moves), 32'd4);
        for (int i = 0; i < 4 && i < dir_log.size(); i++) chk("t6_order", 32'(dir_log[i]), 32'(i));
        do_reset();
        btn = 4'hF; step(); btn = '0;
        n = 0;
        while (!(u_if.move_valid && moves == 1) && n < 30) begin step(); n++; end
        chk("t6_second_seen", 32'(n < 30), 32'd1);
        rst_n = 1'b0; step(); rst_n = 1'b1;
        chk("t6_rst_valid", 32'(u_if.move_valid), 32'd0);
        clear_stats();
        run(30);
        chk("t6_after_rst", 32'(moves), 32'd0);

        // randomized run against the model
        do_reset();
        tick_div = -1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) btn = btn ^ 4'(1 << $urandom_range(0, 3));
            tick = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) en = 4'($urandom_range(0, 15));
            ready = ($urandom_range(0, 3) != 0);
            rst_n = ($urandom_range(0, 499) != 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/move_scheduler.md
Name: move_scheduler

Overview:
- Converts player button activity and a gravity timer into a serialized stream of single-step move commands for the piece-position updater.
- Gates each candidate move with the per-direction enable flags from the collision/enable-compare stage.
- Issues at most one move per handshake, then waits a settle window so the enables can re-evaluate against the new position.
- Sits between input debounce, the enable-compare logic and the position registers.

Parameters:
REPEAT_DELAY, 12, ticks a button must be held before the first auto-repeat move
REPEAT_RATE, 4, ticks between subsequent auto-repeat moves (1..REPEAT_DELAY)
GRAVITY_PERIOD, 30, ticks between gravity down-steps (>=1)
SETTLE_CYCLES, 2, clk cycles idle after each accepted move (>=1)
CNT_W, 8, width of tick counters (must hold max(REPEAT_DELAY, GRAVITY_PERIOD))

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active-low
tick  in  1  one-cycle frame strobe
btn  in  4  debounced button levels, bit index = direction
en  in  4  move enables from the enable-compare stage; 1 = direction free
move_valid  out  1  move command valid
move_dir  out  2  direction of the move command
move_ready  in  1  position updater accepts the command
landed  out  1  one-cycle pulse: gravity step blocked, so the piece has landed
busy  out  1  high in ISSUE or SETTLE

Behaviour:
- Direction encoding: 0 = up, 1 = down, 2 = left, 3 = right. This encoding applies to btn, en and move_dir.
- Reset, synchronous on rst_n = 0:
  - state IDLE.
  - move_valid, move_dir, landed and busy all 0.
  - All counters, pending flags and btn_q are 0.
  - rr_ptr is 0.
  - Reset mid-ISSUE drops move_valid at the next edge. There is no partial command.
- Press detection:
  - Edge is btn & ~btn_q, with btn_q registered each cycle.
  - A button held through reset release produces one edge in the first cycle after release.
- Auto-repeat, per direction:
  - A press edge sets req[d] and clears rpt_cnt[d].
  - While btn[d] is held, each tick increments rpt_cnt[d].
  - When rpt_cnt[d] reaches REPEAT_DELAY, set req[d] and load rpt_cnt[d] with REPEAT_DELAY-REPEAT_RATE.
  - Release clears rpt_cnt[d] but leaves req[d] pending, so a short tap still moves.
  - Setting req[d] and clearing it in the same cycle: set wins.
- Gravity:
  - grav_cnt counts ticks, wraps at GRAVITY_PERIOD-1 and sets grav_pend on the wrap.
  - Setting grav_pend and clearing it in the same cycle: set wins.
- FSM state IDLE, one decision per cycle:
  - If grav_pend and en[1]=1: grant down, clear grav_pend and req[1], go to ISSUE.
  - If grav_pend and en[1]=0: landed=1 for this cycle, clear grav_pend, stay in IDLE.
  - Otherwise, round-robin search of req starting at rr_ptr; the first pending d is selected.
  - Selected d with en[d]=1: grant d, clear req[d], go to ISSUE.
  - Selected d with en[d]=0: clear req[d] (dropped, not retried), stay in IDLE.
  - en is sampled only at grant time.
- FSM state ISSUE:
  - move_valid=1 and move_dir is held stable until move_ready.
  - A change in en does not retract the command.
  - On move_valid & move_ready: rr_ptr <= granted d + 1 (mod 4), load settle counter with SETTLE_CYCLES, go to SETTLE.
- FSM state SETTLE:
  - Decrement the settle counter.
  - At 1, go to IDLE, so the block is idle for exactly SETTLE_CYCLES cycles.
- Requests and gravity expiries arriving during ISSUE or SETTLE are latched. At most one pending per direction; duplicates merge.
- Latency: the move_valid rise is registered. With all enables set and nothing pending, it rises 2 cycles after the press-edge cycle.
- Throughput: at most 1 move per (1 + SETTLE_CYCLES) cycles when move_ready=1.
- landed and move_valid are never high in the same cycle.
- tick arriving while btn is released does not advance rpt_cnt.

Decomposition:
- Shared package game_pkg:
  - dir_t, a 2-bit typedef.
  - Constants DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT.
  - NUM_DIRS = 4.
- Sub-module btn_autorepeat:
  - Instantiated 4x.
  - Inputs: clk, rst_n, tick, btn, clr.
  - Output: req.
  - Contains the edge detector, rpt_cnt and the sticky req.
- move_scheduler holds the gravity counter, round-robin arbiter and FSM.

Test Plan:
1. en=4'hF, move_ready=1, btn[2] high for 1 cycle → move_valid=1 with move_dir=2 exactly 2 cycles after the edge, for 1 cycle. busy is high for 1+2 cycles. No further moves.
2. btn[3] held 24 ticks (tick every 10 clk), GRAVITY_PERIOD large → exactly 5 moves with dir 3: at the press, and at ticks 12, 16, 20 and 24.
3. GRAVITY_PERIOD=3:
   - en[1]=0 at the third tick → landed pulses 1 cycle and there is no move_valid.
   - Repeat with en[1]=1 → move_dir=1 issued.
4. move_ready held low 5 cycles with btn[0] tapped during the stall → move_valid and move_dir=2 are stable for all 5 cycles. The up move is issued SETTLE_CYCLES+1 cycles after acceptance.
5. en[2]=0, tap left → no move_valid, req dropped. Raising en[2] later produces no move.
6. Simultaneous taps of all four buttons with rr_ptr=0 → order of issue is 0, 1, 2, 3. Asserting rst_n=0 during the second ISSUE → move_valid=0 at the next edge and no further moves.
